vga_anim_ctrl: RTL and testbench

Frame-rate animation controller that sits directly upstream of the VGA pattern generator. It detects each vsync rising edge from the timing generator in the `clk` domain and produces a one-cycle `frame_tick`. On each tick it advances a frame counter, wrapped scroll offsets and a fade-level state machine. This replaces the pattern generator's vsync-clocked counter with fully synchronous, pausable, speed- and direction-controlled animation state.

---
 rtl/vga_anim_pkg.sv | 27 ++
 rtl/vga_wrap_step.sv | 34 +++
 rtl/vga_anim_ctrl.sv | 160 ++++++++++++++++
 tb/tb_vga_anim_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_anim_pkg.sv
// vga_anim_pkg: shared types, display constants and helpers for the VGA animation controller.
// Revision 1.0
`default_nettype none

package vga_anim_pkg;

  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;

  localparam int DEF_STEP_FRAMES  = 8;
  localparam int DEF_HOLD_FRAMES  = 256;
  localparam int DEF_BLANK_FRAMES = 32;

  typedef enum logic [1:0] {
    BLANK    = 2'd0,
    FADE_IN  = 2'd1,
    HOLD     = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_t;

  function automatic logic [3:0] speed_to_step(input logic [1:0] speed);
    return 4'd1 << speed;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_wrap_step.sv
// vga_wrap_step: combinational modular add/subtract of a small step, result kept in 0..MODULUS-1.
// Revision 1.0
`default_nettype none

module vga_wrap_step #(
  parameter int MODULUS = 640
) (
  input  logic [9:0] value,
  input  logic [3:0] step,
  input  logic       dir,
  output logic [9:0] result
);

  localparam logic [10:0] MOD11 = 11'(MODULUS);

  logic [10:0] value_w;
  logic [10:0] step_w;
  logic [10:0] sum_w;

  // 11-bit intermediates so value+step never overflows before the wrap compare
  always_comb begin
    value_w = {1'b0, value};
    step_w  = {7'd0, step};
    sum_w   = value_w + step_w;
    if (!dir) begin
      result = (sum_w >= MOD11) ? 10'(sum_w - MOD11) : sum_w[9:0];
    end else begin
      result = (value_w < step_w) ? 10'(value_w + MOD11 - step_w) : 10'(value_w - step_w);
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_anim_ctrl.sv
// vga_anim_ctrl: per-frame animation state (frame count, scroll offsets, fade FSM) advanced on vsync rise.
// Revision 1.0
`default_nettype none

module vga_anim_ctrl
  import vga_anim_pkg::*;
#(
  parameter int H_WRAP       = H_DISPLAY,
  parameter int V_WRAP       = V_DISPLAY,
  parameter int STEP_FRAMES  = DEF_STEP_FRAMES,
  parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES,
  parameter int BLANK_FRAMES = DEF_BLANK_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic [4:0] ctrl_in,
  output logic       frame_tick,
  output logic [9:0] frame_cnt,
  output logic [9:0] scroll_x,
  output logic [9:0] scroll_y,
  output logic [1:0] fade_level,
  output logic [1:0] fade_state
);

  localparam logic [7:0] STEP_LAST  = 8'(STEP_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_FRAMES - 1);

  logic        vs_q;
  logic [4:0]  ctrl_s1;
  logic [4:0]  ctrl_s2;
  logic        vs_rise;
  logic        pause;
  logic        fade_en;
  logic        dir;
  logic [3:0]  step;
  logic [9:0]  x_nx;
  logic [9:0]  y_nx;

  fade_state_t state_q;
  fade_state_t state_nx;
  logic [1:0]  level_q;
  logic [1:0]  level_nx;
  logic [7:0]  dwell_q;
  logic [7:0]  dwell_nx;

  assign vs_rise = vsync & ~vs_q;
  assign pause   = ctrl_s2[4];
  assign fade_en = ctrl_s2[3];
  assign dir     = ctrl_s2[2];
  assign step    = speed_to_step(ctrl_s2[1:0]);

  assign fade_level = level_q;
  assign fade_state = state_q;

  vga_wrap_step #(.MODULUS(H_WRAP)) u_wrap_x (
    .value  (scroll_x),
    .step   (step),
    .dir    (dir),
    .result (x_nx)
  );

  vga_wrap_step #(.MODULUS(V_WRAP)) u_wrap_y (
    .value  (scroll_y),
    .step   (4'd1),
    .dir    (dir),
    .result (y_nx)
  );

  // vs_q resets high so a vsync already asserted at reset release is not a rise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q       <= 1'b1;
      ctrl_s1    <= '0;
      ctrl_s2    <= '0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      scroll_x   <= '0;
      scroll_y   <= '0;
    end else begin
      vs_q       <= vsync;
      ctrl_s1    <= ctrl_in;
      ctrl_s2    <= ctrl_s1;
      frame_tick <= vs_rise;
      if (vs_rise && !pause) begin
        frame_cnt <= frame_cnt + 10'd1;
        scroll_x  <= x_nx;
        if (frame_cnt[1:0] == 2'd3) begin
          scroll_y <= y_nx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FADE_IN;
      level_q <= 2'd0;
      dwell_q <= 8'd0;
    end else begin
      state_q <= state_nx;
      level_q <= level_nx;
      dwell_q <= dwell_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    level_nx = level_q;
    dwell_nx = dwell_q;
    if (vs_rise && !pause) begin
      if (!fade_en) begin
        state_nx = HOLD;
        level_nx = 2'd3;
        dwell_nx = 8'd0;
      end else begin
        case (state_q)
          FADE_IN: begin
            if (dwell_q == STEP_LAST) begin
              dwell_nx = 8'd0;
              level_nx = level_q + 2'd1;
              if (level_nx == 2'd3) state_nx = HOLD;
            end else begin
              dwell_nx = dwell_q + 8'd1;
            end
          end
          HOLD: begin
            if (dwell_q == HOLD_LAST) begin
              dwell_nx = 8'd0;
              state_nx = FADE_OUT;
            end else begin
              dwell_nx = dwell_q + 8'd1;
            end
          end
          FADE_OUT: begin
            if (dwell_q == STEP_LAST) begin
              dwell_nx = 8'd0;
              level_nx = level_q - 2'd1;
              if (level_nx == 2'd0) state_nx = BLANK;
            end else begin
              dwell_nx = dwell_q + 8'd1;
            end
          end
          BLANK: begin
            if (dwell_q == BLANK_LAST) begin
              dwell_nx = 8'd0;
              state_nx = FADE_IN;
            end else begin
              dwell_nx = dwell_q + 8'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_anim_ctrl.sv
// tb_vga_anim_ctrl: scoreboard plus fade-schedule table bench for vga_anim_ctrl.
// Revision 1.0
`default_nettype none

module tb_vga_anim_ctrl;

  localparam int HW = 640;
  localparam int VW = 480;
  localparam int SF = 8;
  localparam int HF = 256;
  localparam int BF = 32;
  localparam logic [33:0] RESET_PACK = 34'd1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic [4:0] ctrl_in = 5'd0;
  logic       frame_tick;
  logic [9:0] frame_cnt;
  logic [9:0] scroll_x;
  logic [9:0] scroll_y;
  logic [1:0] fade_level;
  logic [1:0] fade_state;

  always #5 clk = ~clk;

  vga_anim_ctrl #(
    .H_WRAP(HW), .V_WRAP(VW), .STEP_FRAMES(SF), .HOLD_FRAMES(HF), .BLANK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .ctrl_in    (ctrl_in),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt),
    .scroll_x   (scroll_x),
    .scroll_y   (scroll_y),
    .fade_level (fade_level),
    .fade_state (fade_state)
  );

  typedef struct {
    int         n;
    logic [1:0] lvl;
    logic [1:0] st;
  } fade_vec_t;

  fade_vec_t   tbl[12];
  int          n_checks = 0;
  int          n_err = 0;
  int          tick_count = 0;
  logic [33:0] sb_q[$];

  int m_cnt, m_x, m_y, m_level, m_dwell, m_state;

  function automatic void model_reset();
    m_cnt = 0; m_x = 0; m_y = 0; m_level = 0; m_dwell = 0; m_state = 1;
  endfunction

  // Reference behaviour: dwell counts ticks already spent in the current step
  function automatic void model_step(input logic [4:0] c);
    int st;
    if (c[4]) return;
    st = 1 << c[1:0];
    if (m_cnt % 4 == 3) m_y = c[2] ? (m_y + VW - 1) % VW : (m_y + 1) % VW;
    m_x = c[2] ? (m_x + HW - st) % HW : (m_x + st) % HW;
    m_cnt = (m_cnt + 1) % 1024;
    if (!c[3]) begin
      m_state = 2; m_level = 3; m_dwell = 0;
    end else begin
      m_dwell++;
      case (m_state)
        1: if (m_dwell == SF) begin m_dwell = 0; m_level++; if (m_level == 3) m_state = 2; end
        2: if (m_dwell == HF) begin m_dwell = 0; m_state = 3; end
        3: if (m_dwell == SF) begin m_dwell = 0; m_level--; if (m_level == 0) m_state = 0; end
        default: if (m_dwell == BF) begin m_dwell = 0; m_state = 1; end
      endcase
    end
  endfunction

  function automatic logic [33:0] model_pack();
    return {10'(m_cnt), 10'(m_x), 10'(m_y), 2'(m_level), 2'(m_state)};
  endfunction

  function automatic logic [33:0] dut_pack();
    return {frame_cnt, scroll_x, scroll_y, fade_level, fade_state};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each tick: settle ctrl through the synchronizer, then a 2-cycle vsync pulse
  task automatic do_tick(input logic [4:0] c);
    ctrl_in = c;
    repeat (3) @(negedge clk);
    model_step(c);
    sb_q.push_back(model_pack());
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_tick) begin
      tick_count++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_tick: got a tick, expected none pending");
      end else begin
        check("tick_outputs", dut_pack(), sb_q.pop_front());
      end
    end
  end

  initial begin
    int idx;
    int t0;
    logic [33:0] snap;
    logic [4:0] c;

    tbl[0]  = '{7,   2'd0, 2'd1};
    tbl[1]  = '{8,   2'd1, 2'd1};
    tbl[2]  = '{16,  2'd2, 2'd1};
    tbl[3]  = '{23,  2'd2, 2'd1};
    tbl[4]  = '{24,  2'd3, 2'd2};
    tbl[5]  = '{279, 2'd3, 2'd2};
    tbl[6]  = '{280, 2'd3, 2'd3};
    tbl[7]  = '{288, 2'd2, 2'd3};
    tbl[8]  = '{296, 2'd1, 2'd3};
    tbl[9]  = '{304, 2'd0, 2'd0};
    tbl[10] = '{335, 2'd0, 2'd0};
    tbl[11] = '{336, 2'd0, 2'd1};

    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_tick", frame_tick, 0);
    check("reset_outputs", dut_pack(), RESET_PACK);

    idx = 0;
    for (int n = 1; n <= 336; n++) begin
      do_tick(n == 4 ? 5'b01100 : 5'b01000);
      if (n == 3) begin
        check("three_ticks", tick_count, 3);
        check("cnt_after3", frame_cnt, 3);
        check("x_after3", scroll_x, 3);
        check("y_after3", scroll_y, 0);
        check("level_after3", fade_level, 0);
      end
      if (n == 4) begin
        check("y_wrap_up", scroll_y, 479);
        check("x_dir1", scroll_x, 2);
      end
      if (idx < 12 && n == tbl[idx].n) begin
        check("tbl_level", fade_level, tbl[idx].lvl);
        check("tbl_state", fade_state, tbl[idx].st);
        idx++;
      end
      if (n == 290) begin
        snap = dut_pack();
        t0 = tick_count;
        repeat (10) do_tick(5'b11000);
        check("pause_ticks", tick_count - t0, 10);
        check("pause_hold", dut_pack(), snap);
      end
    end
    check("table_done", idx, 12);

    // vsync already high when reset releases
    rst_n = 1'b0;
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("reset_outputs2", dut_pack(), RESET_PACK);
    t0 = tick_count;
    repeat (5) @(negedge clk);
    check("no_tick_high_release", tick_count - t0, 0);
    vsync = 1'b0;
    @(negedge clk);

    for (int n = 1; n <= 1024; n++) begin
      c = 5'b01010;
      if (n == 160) c = 5'b01011;
      if (n == 161) c = 5'b01100;
      if (n == 162) c = 5'b01111;
      if (n == 311) c = 5'b00010;
      if (n == 311) check("blank_before_disable", fade_state, 0);
      if (n == 160) check("x_at_636", scroll_x, 636);
      do_tick(c);
      if (n == 1)    check("first_tick_after_high", frame_cnt, 1);
      if (n == 160)  check("x_wrap_fwd", scroll_x, 4);
      if (n == 161)  check("x_dir1_step1", scroll_x, 3);
      if (n == 162)  check("x_wrap_back", scroll_x, 635);
      if (n == 311) begin
        check("force_hold_state", fade_state, 2);
        check("force_hold_level", fade_level, 3);
      end
      if (n == 1023) check("cnt_max", frame_cnt, 1023);
      if (n == 1024) begin
        check("cnt_wrap", frame_cnt, 0);
        check("hold_at_wrap", fade_state, 2);
      end
    end

    // Reset mid-HOLD with a coincident vsync rise
    rst_n = 1'b0;
    vsync = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("reset_mid_hold", dut_pack(), RESET_PACK);
    check("reset_mid_hold_tick", frame_tick, 0);
    t0 = tick_count;
    repeat (4) @(negedge clk);
    check("no_tick_after_reset", tick_count - t0, 0);
    vsync = 1'b0;
    @(negedge clk);
    do_tick(5'b01000);
    check("cnt_after_reset", frame_cnt, 1);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
